uart_echo_checker: RTL
======================

# uart_echo_checker

Self-contained UART loopback exerciser: on command it serialises a known byte sequence onto its TX line, waits for each byte to be echoed back on its RX line, and compares. It counts mismatches, framing errors and timeouts, then reports pass/fail. It drives the far end of a UART echo device (e.g. a board running an RX-to-TX loopback) from a second FPGA or in simulation. Serialiser and deserialiser are internal; no other UART modules are instantiated.

## Interface
- DATA_BITS, 8: payload bits per frame, LSB first.
- STOP_BITS, 1: stop bits transmitted and checked.
- CLKS_PER_BIT, 1250: clocks per bit period (12 MHz / 9600).
- NUM_BYTES, 256: bytes per run, 1..65535.
- TIMEOUT_BITS, 20: echo timeout in bit periods.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled only in IDLE/DONE.
- uart_rx_pin  in  1  echoed serial input, asynchronous.
- uart_tx_pin  out  1  serial output, idle high.
- busy  out  1  run in progress.
- done  out  1  run finished, held until next start.
- pass  out  1  valid while done: err_count == 0.
- err_count  out  16  mismatches + framing errors + timeouts, saturating at 0xFFFF.

## Operation
- States: IDLE -> SEND -> WAIT -> CHECK -> (SEND | DONE); DONE -> SEND on start.
- IDLE/DONE + start=1: clear err_count, byte index and pattern generator; busy=1, done=0, pass=0; enter SEND. start ignored in any other state.
- SEND: transmit one frame (start bit 0, DATA_BITS LSB first, STOP_BITS ones); at end of last stop bit enter WAIT.
- WAIT: timeout counter counts TIMEOUT_BITS*CLKS_PER_BIT clocks. Receiver frame complete -> latch byte and framing flag, enter CHECK. Timeout -> err_count+1, enter CHECK marked "no compare".
- CHECK (1 cycle): if not timed out, +1 on data mismatch or framing error (counted once per byte). Advance pattern; if index == NUM_BYTES-1 enter DONE (busy=0, done=1, pass=(err_count==0) using the final count), else index+1, SEND.
- Receiver always runs: 2-flop synchroniser; falling edge while idle starts a frame; samples at CLKS_PER_BIT/2 into start bit, then every CLKS_PER_BIT. Start bit high at midpoint -> abort silently (glitch). Any stop bit low -> framing error. Frames completing outside WAIT are discarded (late echoes never counted against the next byte).
- Counters sized with $clog2; err_count holds at 0xFFFF.

## Timing
- Reset values: uart_tx_pin=1, busy=0, done=0, pass=0, err_count=0, state IDLE, LFSR=seed.
- start sampled at edge N -> busy=1 at N+1, start bit on uart_tx_pin from N+1.
- Frame length exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT clocks.
- Ideal loopback: echo completes ~ (DATA_BITS+1.5)*CLKS_PER_BIT + 3 clocks after its start bit; CHECK is one cycle, next start bit the cycle after.
- Timeout byte costs frame + TIMEOUT_BITS*CLKS_PER_BIT + 2 clocks.
- rst_n low at any point (mid-frame included): immediately returns all outputs to reset values; no partial frame resumes.

## Configuration
- ECHO_CHECKER_LFSR_EN defined: byte k = low DATA_BITS of a 16-bit Galois LFSR (taps 0xB400, right shift, seed 0xACE1), advanced once per CHECK; bytes 0xE1, 0x70, ...
- Undefined: byte k = k mod 2^DATA_BITS (0x00, 0x01, ...); LFSR logic absent.

## Test plan
- Reset: rst_n low then high, no start -> uart_tx_pin=1, busy=done=pass=0, err_count=0 indefinitely.
- Wire loopback, NUM_BYTES=4, CLKS_PER_BIT=16, macro off -> frames 0x00..0x03 on TX, done=1, pass=1, err_count=0, busy low after 4 frames.
- Same with ECHO_CHECKER_LFSR_EN -> first two frames 0xE1 then 0x70; pass=1.
- uart_rx_pin tied high, NUM_BYTES=3 -> each byte times out after TIMEOUT_BITS*16 clocks; done with err_count=3, pass=0.
- Bench inverts bit 0 of echo of byte 1 and forces byte 2's stop bit low, NUM_BYTES=4 -> err_count=2, pass=0; second start re-runs clean -> err_count=0, pass=1.
- rst_n pulsed low mid-data-bit of byte 1 -> uart_tx_pin=1, busy=0 next edge; subsequent start begins again from byte 0.

Source files
------------

// File: rtl/uart_echo_checker.sv
// UART loopback exerciser: sends NUM_BYTES pattern bytes, checks each echo, counts errors.
// Define ECHO_CHECKER_LFSR_EN for a 16-bit Galois LFSR pattern instead of a byte counter.
module uart_echo_checker #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1250,
  parameter int NUM_BYTES    = 256,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        uart_rx_pin,
  output logic        uart_tx_pin,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count
);
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int TO_CLKS    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W       = $clog2(TO_CLKS);
  localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] FIRST_STOP = BIT_W'(DATA_BITS + 1);
  localparam logic [TO_W-1:0]  TO_END     = TO_W'(TO_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);

`ifdef ECHO_CHECKER_LFSR_EN
  localparam int PAT_W = 16;
  localparam logic [PAT_W-1:0] PAT_SEED = 16'hACE1;
  function automatic logic [PAT_W-1:0] pat_step(input logic [PAT_W-1:0] p);
    return (p >> 1) ^ (p[0] ? 16'hB400 : 16'h0000);
  endfunction
`else
  localparam int PAT_W = DATA_BITS;
  localparam logic [PAT_W-1:0] PAT_SEED = '0;
  function automatic logic [PAT_W-1:0] pat_step(input logic [PAT_W-1:0] p);
    return p + PAT_W'(1);
  endfunction
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t                state, next_state;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [BIT_W-1:0]      tx_bit;
  logic [CNT_W-1:0]      tx_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  timed_out;
  logic [IDX_W-1:0]      byte_idx;
  logic [PAT_W-1:0]      pat, pat_adv;
  logic [DATA_BITS-1:0]  load_byte;
  logic                  tx_last, to_last, load, cmp_err, in_window;

  logic                  rx_meta, rx_sync, rx_prev, rx_active, rx_sample;
  logic [CNT_W-1:0]      rx_cnt;
  logic [BIT_W-1:0]      rx_bit;
  logic [DATA_BITS-1:0]  rx_shift, rx_byte;
  logic                  rx_ferr, rx_byte_ferr, rx_owned, rx_pending;

  assign tx_last   = (state == S_SEND) && (tx_cnt == BIT_END) && (tx_bit == LAST_BIT);
  assign to_last   = (to_cnt == TO_END);
  assign pat_adv   = pat_step(pat);
  assign load      = (next_state == S_SEND) && (state != S_SEND);
  assign load_byte = (state == S_CHECK) ? pat_adv[DATA_BITS-1:0] : PAT_SEED[DATA_BITS-1:0];
  assign cmp_err   = !timed_out && ((rx_byte != pat[DATA_BITS-1:0]) || rx_byte_ferr);
  assign in_window = (state == S_SEND) || (state == S_WAIT);
  assign rx_sample = rx_active && (rx_cnt == ((rx_bit == '0) ? HALF_END : BIT_END));

  // NOTE: next_state gets its default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = S_SEND;
      S_SEND:         if (tx_last) next_state = S_WAIT;
      S_WAIT:         if (rx_pending || to_last) next_state = S_CHECK;
      S_CHECK:        next_state = (byte_idx == LAST_IDX) ? S_DONE : S_SEND;
      default:        next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      uart_tx_pin <= 1'b1;
      tx_shift    <= '1;
      tx_bit      <= '0;
      tx_cnt      <= '0;
      to_cnt      <= '0;
      timed_out   <= 1'b0;
      byte_idx    <= '0;
      pat         <= PAT_SEED;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
    end else begin
      state <= next_state;

      if (load) begin
        tx_shift    <= {{STOP_BITS{1'b1}}, load_byte, 1'b0};
        tx_bit      <= '0;
        tx_cnt      <= '0;
        uart_tx_pin <= 1'b0;
      end else if (state == S_SEND) begin
        if (tx_cnt == BIT_END) begin
          tx_cnt      <= '0;
          tx_bit      <= tx_bit + 1'b1;
          tx_shift    <= {1'b1, tx_shift[FRAME_BITS-1:1]};
          uart_tx_pin <= tx_last ? 1'b1 : tx_shift[1];
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end else begin
        uart_tx_pin <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: if (start) begin
          err_count <= '0;
          byte_idx  <= '0;
          pat       <= PAT_SEED;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
        S_SEND: if (tx_last) begin
          to_cnt    <= '0;
          timed_out <= 1'b0;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (!rx_pending && to_last) begin
            timed_out <= 1'b1;
            err_count <= sat_inc(err_count);
          end
        end
        S_CHECK: begin
          if (cmp_err) err_count <= sat_inc(err_count);
          pat <= pat_adv;
          if (byte_idx == LAST_IDX) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0) && !cmp_err;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The echo of a byte finishes during its own stop bit, so frames that start and finish
  // inside SEND/WAIT of the current byte are accepted; anything older is dropped on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      rx_active    <= 1'b0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_ferr      <= 1'b0;
      rx_owned     <= 1'b0;
      rx_pending   <= 1'b0;
      rx_byte      <= '0;
      rx_byte_ferr <= 1'b0;
    end else begin
      rx_meta <= uart_rx_pin;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (!rx_active) begin
        if (rx_prev && !rx_sync) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
          rx_ferr   <= 1'b0;
          rx_owned  <= in_window;
        end
      end else if (rx_sample) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == '0) begin
          if (rx_sync) rx_active <= 1'b0;
        end else if (rx_bit < FIRST_STOP) begin
          rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
        end else if (rx_bit != LAST_BIT) begin
          rx_ferr <= rx_ferr | !rx_sync;
        end else begin
          rx_active <= 1'b0;
          if (rx_owned && in_window) begin
            rx_pending   <= 1'b1;
            rx_byte      <= rx_shift;
            rx_byte_ferr <= rx_ferr | !rx_sync;
          end
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end

      if (load) begin
        rx_owned   <= 1'b0;
        rx_pending <= 1'b0;
      end
    end
  end
endmodule
